// File: rtl/add_sub_pipe.sv
// Pipelined adder/subtractor: the WIDTH-bit add is split into STAGES equal chunks that
// ripple a registered carry from stage to stage, with valid/ready flow control and flush.
module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam int NI   = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0] v_q, v_d, adv, ld_en;
    logic              accept;

    // Intermediate slots; the last slot is the output register set below.
    logic [WIDTH-1:0] a_q [NI];
    logic [WIDTH-1:0] b_q [NI];
    logic [WIDTH-1:0] r_q [NI];
    logic             c_q [NI];
    logic [TAG_W-1:0] t_q [NI];

    logic [WIDTH-1:0] ld_a [STAGES];
    logic [WIDTH-1:0] ld_b [STAGES];
    logic [WIDTH-1:0] ld_r [STAGES];
    logic             ld_c [STAGES];
    logic [TAG_W-1:0] ld_t [STAGES];
    logic [WIDTH-1:0] nx_r [STAGES];
    logic             nx_c [STAGES];
    logic [CW:0]      csum [STAGES];
    logic             ovf_d;

    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             ovf_q;
    logic [TAG_W-1:0] tag_q;

    // A slot advances when any slot downstream of it is empty or the consumer is taking.
    always_comb begin : flow
        logic free;
        free = out_ready;
        adv  = '0;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = v_q[k] && free;
            free   = free || !v_q[k];
        end
        in_ready = free && !flush && !reset;
        accept   = in_valid && in_ready;
        ld_en    = '0;
        ld_en[0] = accept;
        for (int k = 1; k < STAGES; k++) begin
            ld_en[k] = adv[k-1];
        end
        v_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = ld_en[k] || (v_q[k] && !adv[k]);
        end
    end

    always_comb begin
        ld_a[0] = in_a;
        ld_b[0] = in_sub ? ~in_b : in_b;
        ld_r[0] = '0;
        ld_c[0] = in_sub;
        ld_t[0] = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            ld_a[k] = a_q[k-1];
            ld_b[k] = b_q[k-1];
            ld_r[k] = r_q[k-1];
            ld_c[k] = c_q[k-1];
            ld_t[k] = t_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            csum[k] = {1'b0, ld_a[k][k*CW +: CW]} + {1'b0, ld_b[k][k*CW +: CW]}
                    + {{CW{1'b0}}, ld_c[k]};
            nx_r[k] = ld_r[k];
            nx_r[k][k*CW +: CW] = csum[k][CW-1:0];
            nx_c[k] = csum[k][CW];
        end
        ovf_d = (ld_a[LAST][WIDTH-1] == ld_b[LAST][WIDTH-1])
             && (nx_r[LAST][WIDTH-1] != ld_a[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LAST; k++) begin
            if (ld_en[k]) begin
                a_q[k] <= ld_a[k];
                b_q[k] <= ld_b[k];
                r_q[k] <= nx_r[k];
                c_q[k] <= nx_c[k];
                t_q[k] <= ld_t[k];
            end
        end
    end

    // Output stage: holds while stalled, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            tag_q   <= '0;
        end else if (ld_en[LAST]) begin
            res_q   <= nx_r[LAST];
            carry_q <= nx_c[LAST];
            ovf_q   <= ovf_d;
            tag_q   <= ld_t[LAST];
        end
    end

    assign out_valid  = v_q[LAST];
    assign out_result = res_q;
    assign out_carry  = carry_q;
    assign out_ovf    = ovf_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: a 32-bit/2-stage and a 64-bit/4-stage instance checked by
// vector tables, directed flow-control sequences and a randomized arithmetic model.
module tb_add_sub_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [4:0]  in_tag, out_tag;
    logic        out_carry, out_ovf;

    logic        flush4, in_valid4, in_ready4, in_sub4, out_valid4, out_ready4;
    logic [63:0] in_a4, in_b4, out_result4;
    logic [4:0]  in_tag4, out_tag4;
    logic        out_carry4, out_ovf4;

    add_sub_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_sub(in_sub), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_carry(out_carry),
        .out_ovf(out_ovf), .out_tag(out_tag)
    );

    add_sub_pipe #(.WIDTH(64), .STAGES(4), .TAG_W(5)) dut4 (
        .clk(clk), .reset(reset), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_sub(in_sub4), .in_a(in_a4), .in_b(in_b4), .in_tag(in_tag4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_result(out_result4), .out_carry(out_carry4),
        .out_ovf(out_ovf4), .out_tag(out_tag4)
    );

    typedef struct {
        logic [63:0] r;
        logic        c;
        logic        o;
        logic [4:0]  t;
        int          acc;
    } exp_t;

    typedef struct {
        logic        sub;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        logic [63:0] r;
        logic        c;
        logic        o;
    } vec_t;

    exp_t q2[$];
    exp_t q4[$];
    vec_t tbl32 [9];
    vec_t tbl64 [4];

    int          cyc, n_cmp, n_fail, base;
    int          acc_cnt [2];
    bit          last_acc [2];
    bit          prev_hold [2];
    logic [63:0] hold_r [2];
    logic [4:0]  hold_t [2];
    logic [1:0]  hold_co [2];
    bit          ov_en, ov4_en;
    exp_t        ov_e, ov4_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference arithmetic: plain unsigned sum/difference and signed range test.
    function automatic exp_t model(input int w, input logic sub, input logic [63:0] a,
                                   input logic [63:0] b, input logic [4:0] t);
        exp_t e;
        logic [63:0] mask, ua, ub;
        logic [64:0] wide;
        logic signed [66:0] sa, sb, ss, lim;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ua   = a & mask;
        ub   = b & mask;
        wide = sub ? ({1'b0, ua} - {1'b0, ub}) : ({1'b0, ua} + {1'b0, ub});
        e.r  = wide[63:0] & mask;
        e.c  = sub ? (ua >= ub) : (((wide >> w) & 65'd1) != 65'd0);
        lim  = 67'sd1 <<< (w - 1);
        sa   = $signed({3'b000, ua});
        sb   = $signed({3'b000, ub});
        if (ua[w-1]) sa = sa - (lim <<< 1);
        if (ub[w-1]) sb = sb - (lim <<< 1);
        ss   = sub ? (sa - sb) : (sa + sb);
        e.o  = (ss >= lim) || (ss < -lim);
        e.t  = t;
        e.acc = 0;
        return e;
    endfunction

    function automatic int qsize(input int p);
        return (p == 0) ? q2.size() : q4.size();
    endfunction
    function automatic exp_t qhead(input int p);
        return (p == 0) ? q2[0] : q4[0];
    endfunction
    function automatic exp_t qpop(input int p);
        if (p == 0) return q2.pop_front();
        return q4.pop_front();
    endfunction
    function automatic void qpush(input int p, input exp_t e);
        if (p == 0) q2.push_back(e);
        else q4.push_back(e);
    endfunction
    function automatic void qclr(input int p);
        if (p == 0) q2.delete();
        else q4.delete();
    endfunction

    task automatic port_step(input int p, input int st, input int w, input logic rdy,
                             input logic vld, input logic ordy, input logic fl, input logic ivld,
                             input logic isub, input logic [63:0] ia, input logic [63:0] ib,
                             input logic [4:0] itag, input logic [63:0] res, input logic c,
                             input logic o, input logic [4:0] t, input bit oen, input exp_t oe);
        exp_t  e;
        bit    exp_v;
        string px;
        px = (p == 0) ? "p32." : "p64.";
        chk({px, "in_ready"}, rdy, !reset && !fl && (ordy || qsize(p) < st));
        exp_v = 1'b0;
        if (qsize(p) > 0) exp_v = (cyc >= qhead(p).acc + st);
        chk({px, "out_valid"}, vld, exp_v);
        if (prev_hold[p] && vld) begin
            chk({px, "stall_result"}, res, hold_r[p]);
            chk({px, "stall_tag"}, t, hold_t[p]);
            chk({px, "stall_flags"}, {c, o}, hold_co[p]);
        end
        if (vld && ordy && !fl && !reset && qsize(p) > 0) begin
            e = qpop(p);
            chk({px, "result"}, res, e.r);
            chk({px, "carry"}, c, e.c);
            chk({px, "ovf"}, o, e.o);
            chk({px, "tag"}, t, e.t);
        end
        prev_hold[p] = vld && !ordy && !fl && !reset;
        hold_r[p]    = res;
        hold_t[p]    = t;
        hold_co[p]   = {c, o};
        last_acc[p]  = ivld && rdy;
        if (reset || fl) begin
            qclr(p);
        end else if (last_acc[p]) begin
            e = oen ? oe : model(w, isub, ia, ib, itag);
            e.acc = cyc;
            qpush(p, e);
            acc_cnt[p]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        port_step(0, 2, 32, in_ready, out_valid, out_ready, flush, in_valid, in_sub,
                  {32'd0, in_a}, {32'd0, in_b}, in_tag, {32'd0, out_result}, out_carry,
                  out_ovf, out_tag, ov_en, ov_e);
        port_step(1, 4, 64, in_ready4, out_valid4, out_ready4, flush4, in_valid4, in_sub4,
                  in_a4, in_b4, in_tag4, out_result4, out_carry4, out_ovf4, out_tag4,
                  ov4_en, ov4_e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send2(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t);
        int n;
        n = 0;
        in_valid = 1'b1; in_sub = s; in_a = a; in_b = b; in_tag = t;
        do begin
            tick();
            n++;
        end while (!last_acc[0] && n < 20);
        chk("p32.accept", last_acc[0], 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic send4(input logic s, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] t);
        int n;
        n = 0;
        in_valid4 = 1'b1; in_sub4 = s; in_a4 = a; in_b4 = b; in_tag4 = t;
        do begin
            tick();
            n++;
        end while (!last_acc[1] && n < 20);
        chk("p64.accept", last_acc[1], 1'b1);
        in_valid4 = 1'b0;
    endtask

    function automatic logic [63:0] pick(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 64'h7FFF_FFFF_FFFF_FFFF;
            3: v = 64'h8000_0000_0000_0000;
            4: return (64'd1 << (w / 2)) - 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v >> (64 - w);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0;
        in_tag = '0; out_ready = 1'b1;
        flush4 = 1'b0; in_valid4 = 1'b0; in_sub4 = 1'b0; in_a4 = '0; in_b4 = '0;
        in_tag4 = '0; out_ready4 = 1'b1;
        ov_en = 1'b0; ov4_en = 1'b0; ov_e = '{default: '0}; ov4_e = '{default: '0};
        cyc = 0; n_cmp = 0; n_fail = 0;
        acc_cnt[0] = 0; acc_cnt[1] = 0;
        prev_hold[0] = 1'b0; prev_hold[1] = 1'b0;

        tbl32[0] = '{1'b0, 64'h7FFF_FFFF, 64'h1,         5'd3, 64'h8000_0000, 1'b0, 1'b1};
        tbl32[1] = '{1'b1, 64'h0,         64'h1,         5'd4, 64'hFFFF_FFFF, 1'b0, 1'b0};
        tbl32[2] = '{1'b1, 64'h8000_0000, 64'h1,         5'd5, 64'h7FFF_FFFF, 1'b1, 1'b1};
        tbl32[3] = '{1'b0, 64'hFFFF_FFFF, 64'h1,         5'd6, 64'h0,         1'b1, 1'b0};
        tbl32[4] = '{1'b0, 64'h0000_FFFF, 64'h1,         5'd7, 64'h0001_0000, 1'b0, 1'b0};
        tbl32[5] = '{1'b1, 64'h5,         64'h5,         5'd8, 64'h0,         1'b1, 1'b0};
        tbl32[6] = '{1'b0, 64'h8000_0000, 64'h8000_0000, 5'd9, 64'h0,         1'b1, 1'b1};
        tbl32[7] = '{1'b1, 64'h7FFF_FFFF, 64'hFFFF_FFFF, 5'd10, 64'h8000_0000, 1'b0, 1'b1};
        tbl32[8] = '{1'b0, 64'h1234_5678, 64'h0FED_CBA9, 5'd11, 64'h2222_2221, 1'b0, 1'b0};

        tbl64[0] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 5'd1, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
        tbl64[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd2, 64'h0, 1'b1, 1'b0};
        tbl64[2] = '{1'b1, 64'h0, 64'h1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        tbl64[3] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 5'd4, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

        @(posedge clk);
        #1;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("reset.in_ready", in_ready, 1'b1);
        chk("reset.out_valid", out_valid, 1'b0);
        chk("reset.out_result", out_result, 32'h0);
        chk("reset.out_flags", {out_carry, out_ovf}, 2'b00);
        chk("reset.out_tag", out_tag, 5'd0);
        chk("reset.p64_result", out_result4, 64'h0);

        // Vector tables, issued back-to-back.
        for (int i = 0; i < 9; i++) begin
            ov_en = 1'b1;
            ov_e.r = tbl32[i].r; ov_e.c = tbl32[i].c; ov_e.o = tbl32[i].o; ov_e.t = tbl32[i].tag;
            send2(tbl32[i].sub, tbl32[i].a[31:0], tbl32[i].b[31:0], tbl32[i].tag);
        end
        ov_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ov4_en = 1'b1;
            ov4_e.r = tbl64[i].r; ov4_e.c = tbl64[i].c; ov4_e.o = tbl64[i].o; ov4_e.t = tbl64[i].tag;
            send4(tbl64[i].sub, tbl64[i].a, tbl64[i].b, tbl64[i].tag);
        end
        ov4_en = 1'b0;
        repeat (8) tick();

        // Backpressure: two ops fill the pipe, then hold until the consumer is ready.
        out_ready = 1'b0;
        base = acc_cnt[0];
        send2(1'b0, 32'h10, 32'h1, 5'd1);
        send2(1'b0, 32'h20, 32'h2, 5'd2);
        in_valid = 1'b1; in_sub = 1'b0; in_a = 32'h30; in_b = 32'h3; in_tag = 5'd3;
        repeat (3) tick();
        chk("bp.accepts", acc_cnt[0] - base, 2);
        chk("bp.in_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        send2(1'b0, 32'h30, 32'h3, 5'd3);
        send2(1'b1, 32'h40, 32'h4, 5'd4);
        repeat (4) tick();
        chk("bp.drained", acc_cnt[0] - base, 4);

        // Flush with two ops in flight and a simultaneous input.
        send2(1'b0, 32'h1, 32'h2, 5'd7);
        send2(1'b1, 32'h9, 32'h4, 5'd8);
        flush = 1'b1; in_valid = 1'b1; in_a = 32'h55; in_b = 32'h1; in_tag = 5'd9;
        tick();
        chk("flush.rejected", last_acc[0], 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush.out_valid", out_valid, 1'b0);
        send2(1'b0, 32'h100, 32'h200, 5'd10);
        repeat (4) tick();

        // Reset with two ops in flight.
        out_ready = 1'b0;
        send2(1'b0, 32'h3, 32'h4, 5'd11);
        send2(1'b0, 32'h5, 32'h6, 5'd12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst2.in_ready", in_ready, 1'b1);
        chk("rst2.out_valid", out_valid, 1'b0);
        chk("rst2.out_result", out_result, 32'h0);
        chk("rst2.out_flags", {out_carry, out_ovf}, 2'b00);
        chk("rst2.out_tag", out_tag, 5'd0);
        out_ready = 1'b1;
        repeat (6) tick();

        // Randomized traffic with backpressure and occasional flush on both instances.
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sub    = 1'($urandom_range(0, 1));
            in_a      = 32'(pick(32));
            in_b      = 32'(pick(32));
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_valid4  = ($urandom_range(0, 3) != 0);
            in_sub4    = 1'($urandom_range(0, 1));
            in_a4      = pick(64);
            in_b4      = pick(64);
            in_tag4    = 5'($urandom);
            out_ready4 = ($urandom_range(0, 2) != 0);
            flush4     = ($urandom_range(0, 49) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; flush4 = 1'b0; out_ready4 = 1'b1;
        repeat (8) tick();
        chk("final.p32_empty", q2.size(), 0);
        chk("final.p64_empty", q4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/add_sub_pipe.md
ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal values 8 to 64.
REQ-002 Parameter: STAGES, 2, number of pipeline stages; legal values 1 to 4; WIDTH SHALL be divisible by STAGES.
REQ-003 Parameter: TAG_W, 5, width of the sideband tag (destination register id) carried with each operation.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  discards all in-flight operations (pipeline flush on exception).
REQ-008 in_valid  input  1  an operation is presented.
REQ-009 in_ready  output  1  the block accepts an operation this cycle.
REQ-010 in_sub  input  1  0 = a+b, 1 = a-b.
REQ-011 in_a, in_b  input  WIDTH  operands.
REQ-012 in_tag  input  TAG_W  sideband, returned unchanged with the result.
REQ-013 out_valid  output  1  the result is valid.
REQ-014 out_ready  input  1  the consumer takes the result this cycle.
REQ-015 out_result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-016 out_carry  output  1  carry out of the MSB of a + (sub ? ~b : b) + sub; for subtraction, 1 means no borrow.
REQ-017 out_ovf  output  1  signed two's-complement overflow.
REQ-018 out_tag  output  TAG_W  tag of the operation on the output.

Function
REQ-019 The adder SHALL be split into STAGES equal chunks of WIDTH/STAGES bits. Stage k adds chunk k using the registered carry from stage k-1; the operand chunks not yet consumed are carried forward in registers.
REQ-020 Stage 0 carry-in SHALL be in_sub, and b SHALL be inverted when in_sub=1.
REQ-021 Transfers: an input is accepted on a cycle with in_valid && in_ready; an output is taken on a cycle with out_valid && out_ready.
REQ-022 Each stage k has a valid bit v[k] and advances when v[k] && (the next slot is empty or also advancing); the last stage advances when out_ready=1.
REQ-023 in_ready SHALL equal (!v[0] || stage 0 advances) && !flush && !reset; the combinational path from out_ready to in_ready is permitted.
REQ-024 Latency: with out_ready held at 1, an operation accepted in cycle N SHALL present out_valid=1 in cycle N+STAGES.
REQ-025 Throughput SHALL be one operation per cycle when there is no backpressure.
REQ-026 Ordering: results SHALL leave in acceptance order. No operation is dropped or duplicated except by flush or reset.
REQ-027 Stall: while out_valid=1 and out_ready=0, out_result, out_carry, out_ovf and out_tag SHALL stay stable. Earlier stages SHALL fill up to STAGES held operations, after which in_ready=0.
REQ-028 out_ovf SHALL equal (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]), where b_eff is b inverted when in_sub=1; it is computed in the final stage.
REQ-029 Flush: when flush=1, all v[k] SHALL be 0 at the next edge, no transfer is accepted, and out_valid=0 from the next cycle. out_valid may be 1 in the flush cycle itself, but a handshake in that cycle SHALL be ignored by the consumer contract.
REQ-030 Simultaneous flush and in_valid: the input SHALL be rejected (in_ready=0).
REQ-031 Carry propagation across chunk boundaries SHALL be exact for every chunk width, including the all-ones ripple through every chunk.

Reset
REQ-032 When reset=1 at a rising edge, all v[k] SHALL be cleared, so out_valid=0 and in_ready=0 during the reset cycle.
REQ-033 After reset: out_result=0, out_carry=0, out_ovf=0, out_tag=0.
REQ-034 Datapath registers other than the output registers need no reset.
REQ-035 Reset asserted mid-operation SHALL discard every in-flight operation; none reappears after reset is released.
REQ-036 in_ready SHALL be 1 on the first cycle after reset is released.

Verification
REQ-037 WIDTH=32, STAGES=2: add 0x7FFFFFFF+0x00000001, tag 3 -> out_valid 2 cycles later, result 0x80000000, carry 0, ovf 1, tag 3.
REQ-038 Sub 0x00000000-0x00000001 -> result 0xFFFFFFFF, carry 0, ovf 0. Sub 0x80000000-0x00000001 -> result 0x7FFFFFFF, carry 1, ovf 1.
REQ-039 Backpressure: out_ready=0, issue tags 1..4 back-to-back -> in_ready falls after 2 accepts. Raise out_ready -> tags 1,2,3,4 emerge in order, with outputs stable while stalled.
REQ-040 Flush with 2 ops in flight and in_valid=1 in the same cycle -> out_valid=0 from the next cycle, the flush-cycle input is not accepted, and the next op issued completes normally.
REQ-041 WIDTH=64, STAGES=4: 0x00000000FFFFFFFF+1 -> 0x0000000100000000, and 0xFFFFFFFFFFFFFFFF+1 -> 0x0, carry 1, after 4 cycles.
REQ-042 Reset asserted with 2 ops in flight -> no out_valid after reset is released, in_ready=1 on the first cycle after release, and all outputs equal 0.
